// File: rtl/stim_sequencer.sv
// Stimulus sequencer: holds the DUT in reset, then builds LCG stimulus vectors one
// 32-bit word per cycle, applies each atomically and folds the response into a signature.
module stim_sequencer #(
  parameter int IN_W    = 137,
  parameter int OUT_W   = 159,
  parameter int CNT_W   = 16,
  parameter int RST_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      seed,
  input  logic [CNT_W-1:0] cycles,
  output logic             busy,
  output logic             done,
  output logic             dut_rst_n,
  output logic [IN_W-1:0]  in_flat,
  input  logic [OUT_W-1:0] out_flat,
  output logic [31:0]      signature,
  output logic [CNT_W-1:0] vec_cnt
);

  localparam int NWORDS  = (IN_W + 31) / 32;
  localparam int IN_PAD  = NWORDS * 32;
  localparam int OCHUNKS = (OUT_W + 31) / 32;
  localparam int OUT_PAD = OCHUNKS * 32;
  localparam int WIDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(NWORDS - 1);
  localparam logic [3:0]        RST_LAST  = 4'(RST_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RESET = 3'd1,
    S_GEN   = 3'd2,
    S_APPLY = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  function automatic logic [31:0] lcg_step(input logic [31:0] r);
    return r * 32'h41C6_4E6D + 32'h0000_3039;
  endfunction

  // The top chunk is narrower than 32 bits and is zero-extended by the padding.
  function automatic logic [31:0] fold_resp(input logic [OUT_W-1:0] v);
    logic [OUT_PAD-1:0] p;
    logic [31:0]        acc;
    p   = OUT_PAD'(v);
    acc = 32'h0000_0000;
    for (int i = 0; i < OCHUNKS; i++) begin
      acc = acc ^ p[i*32 +: 32];
    end
    return acc;
  endfunction

  state_e              state_q, state_d;
  logic [31:0]         rng_q, rng_d, rng_n;
  logic [IN_PAD-1:0]   shadow_q, shadow_d;
  logic [IN_W-1:0]     in_flat_q, in_flat_d;
  logic [31:0]         sig_q, sig_d;
  logic [CNT_W-1:0]    vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0]    target_q, target_d;
  logic [3:0]          rst_cnt_q, rst_cnt_d;
  logic [WIDX_W-1:0]   widx_q, widx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                dut_rst_n_q, dut_rst_n_d;

  // Next-state and datapath updates for the run sequence.
  always_comb begin
    state_d   = state_q;
    rng_d     = rng_q;
    shadow_d  = shadow_q;
    in_flat_d = in_flat_q;
    sig_d     = sig_q;
    vec_cnt_d = vec_cnt_q;
    target_d  = target_q;
    rst_cnt_d = rst_cnt_q;
    widx_d    = widx_q;
    rng_n     = lcg_step(rng_q);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RESET;
          rng_d     = seed;
          target_d  = cycles;
          sig_d     = 32'h0000_0000;
          vec_cnt_d = '0;
          rst_cnt_d = 4'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RESET: begin
        if (rst_cnt_q == RST_LAST) begin
          widx_d  = '0;
          state_d = (target_q == '0) ? S_DONE : S_GEN;
        end else begin
          rst_cnt_d = rst_cnt_q + 4'd1;
        end
      end
      S_GEN: begin
        rng_d = rng_n;
        for (int k = 0; k < NWORDS; k++) begin
          shadow_d[k*32 +: 32] = (widx_q == WIDX_W'(k)) ? rng_n : shadow_q[k*32 +: 32];
        end
        // The visible vector is only replaced once every word of it is fresh.
        if (widx_q == LAST_WORD) begin
          state_d   = S_APPLY;
          in_flat_d = shadow_d[IN_W-1:0];
        end else begin
          widx_d = widx_q + WIDX_W'(1);
        end
      end
      S_APPLY: begin
        sig_d     = {sig_q[30:0], sig_q[31]} ^ fold_resp(out_flat);
        vec_cnt_d = vec_cnt_q + CNT_W'(1);
        widx_d    = '0;
        state_d   = (vec_cnt_d == target_q) ? S_DONE : S_GEN;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status outputs are decoded from the next state so they register alongside it.
  always_comb begin
    busy_d      = 1'b0;
    done_d      = 1'b0;
    dut_rst_n_d = 1'b1;
    case (state_d)
      S_RESET: begin
        busy_d      = 1'b1;
        dut_rst_n_d = 1'b0;
      end
      S_GEN:   busy_d = 1'b1;
      S_APPLY: busy_d = 1'b1;
      S_DONE:  done_d = 1'b1;
      S_IDLE:  busy_d = 1'b0;
      default: busy_d = 1'b0;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rng_q       <= 32'h0000_0000;
      shadow_q    <= '0;
      in_flat_q   <= '0;
      sig_q       <= 32'h0000_0000;
      vec_cnt_q   <= '0;
      target_q    <= '0;
      rst_cnt_q   <= 4'd0;
      widx_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dut_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rng_q       <= rng_d;
      shadow_q    <= shadow_d;
      in_flat_q   <= in_flat_d;
      sig_q       <= sig_d;
      vec_cnt_q   <= vec_cnt_d;
      target_q    <= target_d;
      rst_cnt_q   <= rst_cnt_d;
      widx_q      <= widx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dut_rst_n_q <= dut_rst_n_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign dut_rst_n = dut_rst_n_q;
  assign in_flat   = in_flat_q;
  assign signature = sig_q;
  assign vec_cnt   = vec_cnt_q;

endmodule

// File: tb/tb_stim_sequencer.sv
// Directed-plus-random bench for stim_sequencer: a per-cycle schedule and an LCG vector
// list derived from the run rules predict every output after every clock edge.
module tb_stim_sequencer;

  localparam int IN_W  = 137;
  localparam int OUT_W = 159;
  localparam int CNT_W = 16;
  localparam int R     = 2;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [31:0]      seed;
  logic [CNT_W-1:0] cycles;
  logic             busy;
  logic             done;
  logic             dut_rst_n;
  logic [IN_W-1:0]  in_flat;
  logic [OUT_W-1:0] out_flat;
  logic [31:0]      signature;
  logic [CNT_W-1:0] vec_cnt;

  int total = 0;
  int bad   = 0;

  logic [IN_W-1:0]  m_in;
  logic [31:0]      m_sig;
  logic [CNT_W-1:0] m_cnt;
  bit               hold_start;
  bit               ones_mode;
  bit               ab;
  logic [31:0]      s;

  stim_sequencer #(
    .IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W), .RST_CYC(R)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .cycles(cycles),
    .busy(busy), .done(done), .dut_rst_n(dut_rst_n), .in_flat(in_flat),
    .out_flat(out_flat), .signature(signature), .vec_cnt(vec_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] lcg(input logic [31:0] r);
    return r * 32'h41C64E6D + 32'h00003039;
  endfunction

  function automatic logic [31:0] fold(input logic [158:0] o);
    logic [159:0] p;
    p = {1'b0, o};
    return p[31:0] ^ p[63:32] ^ p[95:64] ^ p[127:96] ^ p[159:128];
  endfunction

  function automatic logic [158:0] rand_out();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[158:0];
  endfunction

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One run from the start edge to the IDLE cycle after DONE; optionally pulls rst_n at step abort_at.
  task automatic run(input logic [31:0] sd, input int c, input int abort_at, output bit aborted);
    logic [IN_W-1:0] vecs[$];
    logic [31:0]     r;
    logic [31:0]     w[5];
    logic [31:0]     pend_sig;
    logic [CNT_W-1:0] pend_cnt;
    bit              pend;
    bit              eb, ed, er;
    int              n;
    vecs.delete();
    r = sd;
    for (int v = 0; v < c; v++) begin
      for (int k = 0; k < 5; k++) begin
        r = lcg(r);
        w[k] = r;
      end
      vecs.push_back({w[4][8:0], w[3], w[2], w[1], w[0]});
    end
    n = R + 6 * c + 1;
    seed = sd;
    cycles = CNT_W'(c);
    start = 1'b1;
    m_sig = 32'h0;
    m_cnt = '0;
    pend = 1'b0;
    pend_sig = 32'h0;
    pend_cnt = '0;
    aborted = 1'b0;
    for (int i = 0; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (pend) begin
        m_sig = pend_sig;
        m_cnt = pend_cnt;
        pend  = 1'b0;
      end
      if (i < R) begin
        eb = 1'b1; ed = 1'b0; er = 1'b0;
      end else if (i < R + 6 * c) begin
        eb = 1'b1; ed = 1'b0; er = 1'b1;
        if ((i - R) % 6 == 5) m_in = vecs[(i - R) / 6];
      end else if (i == R + 6 * c) begin
        eb = 1'b0; ed = 1'b1; er = 1'b1;
      end else begin
        eb = 1'b0; ed = 1'b0; er = 1'b1;
      end
      check("busy", 160'(busy), 160'(eb));
      check("done", 160'(done), 160'(ed));
      check("dut_rst_n", 160'(dut_rst_n), 160'(er));
      check("in_flat", 160'(in_flat), 160'(m_in));
      check("signature", 160'(signature), 160'(m_sig));
      check("vec_cnt", 160'(vec_cnt), 160'(m_cnt));
      out_flat = ones_mode ? '1 : rand_out();
      if (i >= R && i < R + 6 * c && (i - R) % 6 == 5) begin
        pend_sig = {m_sig[30:0], m_sig[31]} ^ fold(out_flat);
        pend_cnt = m_cnt + CNT_W'(1);
        pend = 1'b1;
      end
      seed = $urandom();
      cycles = CNT_W'($urandom_range(0, 9));
      if (hold_start) start = 1'b1;
      else if (i < n) start = 1'($urandom_range(0, 1));
      else start = 1'b0;
      if (i == abort_at) begin
        rst_n = 1'b0;
        start = 1'b0;
        aborted = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; seed = 32'h0; cycles = '0; out_flat = '0;
    hold_start = 1'b0; ones_mode = 1'b0; m_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 160'(busy), 160'(1'b0));
    check("rst_done", 160'(done), 160'(1'b0));
    check("rst_dut_rst_n", 160'(dut_rst_n), 160'(1'b0));
    check("rst_in_flat", 160'(in_flat), 160'(0));
    check("rst_signature", 160'(signature), 160'(0));
    check("rst_vec_cnt", 160'(vec_cnt), 160'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release_dut_rst_n", 160'(dut_rst_n), 160'(1'b1));
    check("rst_release_busy", 160'(busy), 160'(1'b0));

    // Zero-length run goes straight from RESET to DONE.
    run(32'h1234_5678, 0, -1, ab);
    check("zero_in_flat", 160'(in_flat), 160'(0));
    check("zero_signature", 160'(signature), 160'(0));

    run(32'h0000_0001, 1, -1, ab);
    check("seed1_word0", 160'(in_flat[31:0]), 160'(32'h41C67EA6));
    check("seed1_vec_cnt", 160'(vec_cnt), 160'(1));

    ones_mode = 1'b1;
    run($urandom(), 3, -1, ab);
    check("ones_signature", 160'(signature), 160'(32'h7FFFFFFC));
    check("ones_vec_cnt", 160'(vec_cnt), 160'(3));

    // start held high across two back-to-back runs of the same seed.
    hold_start = 1'b1;
    s = $urandom();
    run(s, 2, -1, ab);
    check("hold1_signature", 160'(signature), 160'(32'h80000001));
    run(s, 2, -1, ab);
    hold_start = 1'b0;
    start = 1'b0;
    check("hold2_signature", 160'(signature), 160'(32'h80000001));
    ones_mode = 1'b0;

    for (int t = 0; t < 4; t++) begin
      run($urandom(), $urandom_range(1, 6), -1, ab);
    end

    // Reset pulled during GEN of the second vector.
    run($urandom(), 5, R + 6 + 2, ab);
    check("abort_reached", 160'(ab), 160'(1'b1));
    @(posedge clk);
    #1;
    m_in = '0;
    check("abort_busy", 160'(busy), 160'(1'b0));
    check("abort_done", 160'(done), 160'(1'b0));
    check("abort_dut_rst_n", 160'(dut_rst_n), 160'(1'b0));
    check("abort_in_flat", 160'(in_flat), 160'(0));
    check("abort_signature", 160'(signature), 160'(0));
    check("abort_vec_cnt", 160'(vec_cnt), 160'(0));
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check("post_abort_done", 160'(done), 160'(1'b0));
      check("post_abort_busy", 160'(busy), 160'(1'b0));
      check("post_abort_dut_rst_n", 160'(dut_rst_n), 160'(1'b1));
    end

    run(32'hEC62B2C8, 100, -1, ab);
    check("long_vec_cnt", 160'(vec_cnt), 160'(100));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stim_sequencer.md
STIM_SEQUENCER -- requirements
Module: stim_sequencer

Interface
REQ-001 The block SHALL expose the following parameters:
- IN_W, default 137: DUT input vector width.
- OUT_W, default 159: DUT output vector width.
- CNT_W, default 16: width of the vector-count field.
- RST_CYC, default 2 (legal range 1..15): number of cycles DUT reset is held.
REQ-002 The block SHALL expose the following ports, clock and reset first:
- clk  in  1: single clock, all logic on the rising edge.
- rst_n  in  1: synchronous active-low reset.
- start  in  1: begin a run; sampled in IDLE only.
- seed  in  32: LCG seed, latched on an accepted start.
- cycles  in  CNT_W: number of vectors to apply, latched on an accepted start.
- busy  out  1: high in RESET, GEN and APPLY.
- done  out  1: one-cycle pulse in DONE.
- dut_rst_n  out  1: active-low reset driven to the DUT.
- in_flat  out  IN_W: stimulus vector to the DUT.
- out_flat  in  OUT_W: DUT response.
- signature  out  32: running response signature.
- vec_cnt  out  CNT_W: number of vectors applied in the current run.

Function
REQ-003 The FSM SHALL have exactly five states: IDLE, RESET, GEN, APPLY, DONE.
REQ-004 In IDLE, start=1 SHALL on the same edge latch seed into rng, latch cycles into the target register, clear signature and vec_cnt, and enter RESET.
REQ-005 start SHALL be ignored in every state other than IDLE; it SHALL NOT restart, extend or abort a run.
REQ-006 RESET behaviour:
- dut_rst_n=0 for exactly RST_CYC cycles.
- Then go to GEN with word index 0, or to DONE if the latched cycles==0.
- dut_rst_n=1 in every state other than RESET.
REQ-007 GEN behaviour:
- One LCG step per cycle: rng <= rng*32'h41C64E6D + 32'h3039, mod 2^32.
- Store the new rng into a shadow vector: word k -> bits [32k+31:32k] for k=0..3, word 4 -> bits [136:128] = rng[8:0].
- After word 4, go to APPLY; GEN lasts exactly 5 cycles per vector.
REQ-008 in_flat SHALL change only on the GEN->APPLY edge, loading the complete shadow vector atomically; it SHALL never expose a partial vector.
REQ-009 APPLY SHALL last exactly one cycle, with in_flat stable.
REQ-010 At the APPLY edge, out_flat SHALL be folded and accumulated:
- fold = XOR of five 32-bit chunks of out_flat; the top chunk [158:128] is zero-extended.
- signature <= {signature[30:0],signature[31]} ^ fold.
- vec_cnt <= vec_cnt+1.
REQ-011 From APPLY the FSM SHALL go to DONE when vec_cnt+1 equals the latched cycles, otherwise to GEN.
REQ-012 Run length SHALL be 1 + RST_CYC + 6*cycles + 1 cycles from the start edge to the return to IDLE; DONE occupies the last cycle.
REQ-013 DONE SHALL assert done=1 and busy=0 for one cycle, then return to IDLE; signature, vec_cnt and in_flat SHALL hold until the next accepted start.
REQ-014 rng SHALL carry over between vectors within a run; each new run SHALL restart from the latched seed.
REQ-015 cycles=2^CNT_W-1 SHALL complete without wrap; vec_cnt SHALL never exceed the latched cycles.

Reset
REQ-016 rst_n=0 SHALL on the next edge force:
- state=IDLE, busy=0, done=0, dut_rst_n=0;
- in_flat=0, signature=0, vec_cnt=0, rng=0.
REQ-017 dut_rst_n SHALL rise to 1 on the first edge with rst_n=1 while in IDLE.
REQ-018 Reset asserted mid-run (any state) SHALL abort the run immediately, with no done pulse.

Verification
REQ-019 seed=1, cycles=1, RST_CYC=2 -> dut_rst_n low 2 cycles; first GEN word=32'h41C67EA6 in in_flat[31:0] at APPLY; done pulses 10 cycles after the start edge; vec_cnt=1.
REQ-020 cycles=0 -> RESET then DONE; done pulses 4 cycles after start; signature=0, in_flat=0.
REQ-021 out_flat tied to all-ones, cycles=3 -> fold=32'h7FFFFFFF*0^... per REQ-010; bench model signature matches after done; vec_cnt=3.
REQ-022 start held high for the whole run -> exactly one run; a second run starts only on the cycle after DONE, reproducing identical in_flat sequence and signature for the same seed.
REQ-023 rst_n pulsed low during GEN of vector 2 -> next cycle IDLE, busy=0, no done, all outputs per REQ-016.
REQ-024 seed=32'hEC62B2C8, cycles=100 -> each in_flat equals the bench's reference LCG vector sequence; in_flat never changes outside the GEN->APPLY edge.
